gbuf_arbiter: RTL and testbench

- Shares one single-port global-buffer RAM (1-cycle read latency) between two requesters: the tpu core's buffer port and a host loader port.
- The host loader fills A/B and drains P.
- The tpu port has absolute priority and is never stalled; the host uses a req/gnt handshake and is served in idle cycles.
- Sits between tpu and each global-buffer instance; one gbuf_arbiter per buffer (A, B, P).

---
 rtl/gbuf_arbiter_pkg.sv | 25 ++
 rtl/gbuf_arbiter_if.sv | 48 ++++
 rtl/gbuf_arbiter_sat_counter.sv | 35 +++
 rtl/gbuf_arbiter.sv | 84 ++++++++
 tb/tb_gbuf_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/gbuf_arbiter_pkg.sv
// rtl/gbuf_arbiter_pkg.sv - shared widths and read-owner encoding for the global-buffer arbiter
package gbuf_arbiter_pkg;

  localparam int GBUF_ADDR_WIDTH     = 12;
  localparam int GBUF_WORD_WIDTH     = 160;
  localparam int GBUF_WAIT_CNT_WIDTH = 16;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_IDLE = 2'd0;
  localparam owner_t OWN_TPU  = 2'd1;
  localparam owner_t OWN_HOST = 2'd2;

  // Who owns the RAM read data returning on the next cycle; writes return nothing.
  function automatic owner_t next_owner(input logic tpu_sel, input logic tpu_we,
                                        input logic host_gnt, input logic host_we);
    if (tpu_sel && !tpu_we) begin
      return OWN_TPU;
    end else if (host_gnt && !host_we) begin
      return OWN_HOST;
    end
    return OWN_IDLE;
  endfunction

endpackage

// File: rtl/gbuf_arbiter_if.sv
// rtl/gbuf_arbiter_if.sv - tpu, host loader and RAM-side signal bundle of one arbiter
interface gbuf_arbiter_if #(
  parameter int ADDR_WIDTH     = 12,
  parameter int WORD_WIDTH     = 160,
  parameter int WAIT_CNT_WIDTH = 16
);

  logic                      tpu_en_i;
  logic                      tpu_we_i;
  logic [ADDR_WIDTH-1:0]     tpu_addr_i;
  logic [WORD_WIDTH-1:0]     tpu_wdata_i;
  logic [WORD_WIDTH-1:0]     tpu_rdata_o;

  logic                      host_req_i;
  logic                      host_we_i;
  logic [ADDR_WIDTH-1:0]     host_addr_i;
  logic [WORD_WIDTH-1:0]     host_wdata_i;
  logic                      host_gnt_o;
  logic                      host_rvalid_o;
  logic [WORD_WIDTH-1:0]     host_rdata_o;
  logic [WAIT_CNT_WIDTH-1:0] host_wait_cnt_o;
  logic                      clr_stats_i;

  logic                      ram_en_o;
  logic                      ram_we_o;
  logic [ADDR_WIDTH-1:0]     ram_addr_o;
  logic [WORD_WIDTH-1:0]     ram_wdata_o;
  logic [WORD_WIDTH-1:0]     ram_rdata_i;

  modport slave (
    input  tpu_en_i, tpu_we_i, tpu_addr_i, tpu_wdata_i,
    output tpu_rdata_o,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, clr_stats_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_wait_cnt_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output tpu_en_i, tpu_we_i, tpu_addr_i, tpu_wdata_i,
    input  tpu_rdata_o,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, clr_stats_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_wait_cnt_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/gbuf_arbiter_sat_counter.sv
// rtl/gbuf_arbiter_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gbuf_arbiter.sv
// rtl/gbuf_arbiter.sv - shares one single-port global buffer between the tpu port and the host loader
module gbuf_arbiter
  import gbuf_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = GBUF_ADDR_WIDTH,
  parameter int WORD_WIDTH     = GBUF_WORD_WIDTH,
  parameter int WAIT_CNT_WIDTH = GBUF_WAIT_CNT_WIDTH
) (
  input logic            clk_i,
  input logic            rst_ni,
  gbuf_arbiter_if.slave  bus
);

  logic                      tpu_sel;
  logic                      host_gnt;
  logic                      wait_inc;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;

  owner_t rd_owner_q;
  owner_t rd_owner_d;

  // The tpu is never stalled; the host only gets cycles the tpu leaves idle.
  assign tpu_sel  = bus.tpu_en_i & rst_ni;
  assign host_gnt = bus.host_req_i & ~bus.tpu_en_i & rst_ni;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (tpu_sel) begin
      ram_en    = 1'b1;
      ram_we    = bus.tpu_we_i;
      ram_addr  = bus.tpu_addr_i;
      ram_wdata = bus.tpu_wdata_i;
    end else if (host_gnt) begin
      ram_en    = 1'b1;
      ram_we    = bus.host_we_i;
      ram_addr  = bus.host_addr_i;
      ram_wdata = bus.host_wdata_i;
    end
  end

  assign bus.ram_en_o    = ram_en;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.host_gnt_o  = host_gnt;

  assign rd_owner_d = next_owner(tpu_sel, bus.tpu_we_i, host_gnt, bus.host_we_i);

  // Async clear drops any read in flight, so no stale rvalid after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_owner_q <= OWN_IDLE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.tpu_rdata_o   = (rd_owner_q == OWN_TPU)  ? bus.ram_rdata_i : '0;
  assign bus.host_rdata_o  = (rd_owner_q == OWN_HOST) ? bus.ram_rdata_i : '0;
  assign bus.host_rvalid_o = (rd_owner_q == OWN_HOST);

  assign wait_inc = bus.host_req_i & ~host_gnt;

  sat_counter #(
    .WIDTH (WAIT_CNT_WIDTH)
  ) u_wait_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (wait_inc),
    .clr_i  (bus.clr_stats_i),
    .cnt_o  (wait_cnt)
  );

  assign bus.host_wait_cnt_o = wait_cnt;

endmodule

// File: tb/tb_gbuf_arbiter.sv
// tb/tb_gbuf_arbiter.sv - scoreboard bench for gbuf_arbiter with a behavioural single-port RAM
module tb_gbuf_arbiter;

  localparam int AW = 12;
  localparam int WW = 160;
  localparam int CW = 4;

  logic clk;
  logic rst_n;

  gbuf_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAIT_CNT_WIDTH(CW)) bus ();

  gbuf_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WAIT_CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WW-1:0] mem     [0:(1<<AW)-1];
  logic [WW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
      else              bus.ram_rdata_i     <= mem[bus.ram_addr_o];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [WW-1:0] tpu_q  [$];
  logic [WW-1:0] host_q [$];
  logic          tpu_pend  = 1'b0;
  logic          host_pend = 1'b0;
  logic [CW-1:0] exp_wait  = '0;
  logic          g;

  function automatic logic [WW-1:0] pat(input logic [AW-1:0] a);
    return {10{4'hC, a}};
  endfunction

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, exp %h", tag, got, exp);
    end
  endtask

  task automatic check_reads();
    check("host_rvalid", WW'(bus.host_rvalid_o), WW'(host_pend));
    if (host_pend) begin
      if (host_q.size() == 0) check("host_q_underflow", 1, 0);
      else                    check("host_rdata", bus.host_rdata_o, host_q.pop_front());
    end else begin
      check("host_rdata_idle", bus.host_rdata_o, '0);
    end
    if (tpu_pend) begin
      if (tpu_q.size() == 0) check("tpu_q_underflow", 1, 0);
      else                   check("tpu_rdata", bus.tpu_rdata_o, tpu_q.pop_front());
    end else begin
      check("tpu_rdata_idle", bus.tpu_rdata_o, '0);
    end
    check("wait_cnt", WW'(bus.host_wait_cnt_o), WW'(exp_wait));
  endtask

  task automatic cycle(input logic te, input logic tw, input logic [AW-1:0] ta,
                       input logic [WW-1:0] td, input logic hr, input logic hw,
                       input logic [AW-1:0] ha, input logic [WW-1:0] hd,
                       input logic cl, output logic granted);
    logic          eg;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed;
    logic          ew;
    @(negedge clk);
    check_reads();
    bus.tpu_en_i     = te;
    bus.tpu_we_i     = tw;
    bus.tpu_addr_i   = ta;
    bus.tpu_wdata_i  = td;
    bus.host_req_i   = hr;
    bus.host_we_i    = hw;
    bus.host_addr_i  = ha;
    bus.host_wdata_i = hd;
    bus.clr_stats_i  = cl;
    #1;
    eg = hr & ~te;
    ew = te ? tw : (eg ? hw : 1'b0);
    ea = te ? ta : (eg ? ha : '0);
    ed = te ? td : (eg ? hd : '0);
    check("host_gnt", WW'(bus.host_gnt_o), WW'(eg));
    check("ram_en",   WW'(bus.ram_en_o),   WW'(te | eg));
    check("ram_we",   WW'(bus.ram_we_o),   WW'(ew));
    check("ram_addr", WW'(bus.ram_addr_o), WW'(ea));
    check("ram_wdata", bus.ram_wdata_o, ed);
    if (cl)                            exp_wait = '0;
    else if (hr && !eg && !(&exp_wait)) exp_wait = exp_wait + 1'b1;
    tpu_pend  = te & ~tw;
    host_pend = eg & ~hw;
    if (te && tw)        ref_mem[ta] = td;
    else if (te)         tpu_q.push_back(ref_mem[ta]);
    else if (eg && hw)   ref_mem[ha] = hd;
    else if (eg)         host_q.push_back(ref_mem[ha]);
    granted = eg;
  endtask

  task automatic idle(input logic cl);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cl, g);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]     = pat(AW'(a));
      ref_mem[a] = pat(AW'(a));
    end
    bus.ram_rdata_i  = '0;
    rst_n            = 1'b0;
    bus.tpu_en_i     = 1'b0;
    bus.tpu_we_i     = 1'b1;
    bus.tpu_addr_i   = 12'hABC;
    bus.tpu_wdata_i  = rnd_word();
    bus.host_req_i   = 1'b1;
    bus.host_we_i    = 1'b1;
    bus.host_addr_i  = 12'h123;
    bus.host_wdata_i = rnd_word();
    bus.clr_stats_i  = 1'b0;
    #2;
    check("rst_gnt",    WW'(bus.host_gnt_o),      0);
    check("rst_ram_en", WW'(bus.ram_en_o),        0);
    check("rst_ram_we", WW'(bus.ram_we_o),        0);
    check("rst_addr",   WW'(bus.ram_addr_o),      0);
    check("rst_wdata",  bus.ram_wdata_o,          0);
    check("rst_rvalid", WW'(bus.host_rvalid_o),   0);
    check("rst_wait",   WW'(bus.host_wait_cnt_o), 0);
    repeat (2) @(negedge clk);
    bus.host_req_i = 1'b0;
    rst_n          = 1'b1;
    #1;
    check("xsafe_en",   WW'(bus.ram_en_o),   0);
    check("xsafe_addr", WW'(bus.ram_addr_o), 0);

    // host only: write then read back 0x005
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h005, 160'h0A000B, 1'b0, g);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h005, rnd_word(), 1'b0, g);
    idle(1'b0);
    check("host_only_mem", ref_mem[12'h005], 160'h0A000B);

    // conflict: tpu wins, host granted on the following idle cycle
    idle(1'b1);
    cycle(1'b1, 1'b0, 12'h100, '0, 1'b1, 1'b0, 12'h200, '0, 1'b0, g);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h200, '0, 1'b0, g);
    check("conflict_wait", WW'(bus.host_wait_cnt_o), 1);
    idle(1'b0);

    // streaming tpu reads block the host for ten cycles
    idle(1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, 12'h050, '0, 1'b0, g);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h050, '0, 1'b0, g);
    check("stream_wait", WW'(bus.host_wait_cnt_o), 10);
    idle(1'b0);

    // alternate host and tpu reads every cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(12'h300 + i), '0, 1'b0, g);
      cycle(1'b1, 1'b0, AW'(12'h400 + i), '0, 1'b0, 1'b0, '0, '0, 1'b0, g);
    end
    idle(1'b0);

    // saturation: host blocked by 20 tpu writes
    idle(1'b1);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'b1, AW'(12'h600 + i), rnd_word(), 1'b1, 1'b0, 12'h600, '0, 1'b0, g);
    idle(1'b0);
    check("sat_held", WW'(bus.host_wait_cnt_o), 15);
    idle(1'b1);
    idle(1'b0);
    check("sat_clr", WW'(bus.host_wait_cnt_o), 0);
    cycle(1'b1, 1'b0, 12'h605, '0, 1'b0, 1'b0, '0, '0, 1'b0, g);
    idle(1'b0);

    // reset while a granted host read is in flight
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h005, '0, 1'b0, g);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",   WW'(bus.host_gnt_o), 0);
    check("mid_rst_en",    WW'(bus.ram_en_o),   0);
    check("mid_rst_addr",  WW'(bus.ram_addr_o), 0);
    check("mid_rst_wdata", bus.ram_wdata_o,     0);
    host_pend = 1'b0;
    tpu_pend  = 1'b0;
    host_q.delete();
    tpu_q.delete();
    exp_wait = '0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_rvalid", WW'(bus.host_rvalid_o),   0);
      check("mid_rst_rdata",  bus.host_rdata_o,         0);
      check("mid_rst_wait",   WW'(bus.host_wait_cnt_o), 0);
      check("mid_rst_ram_en", WW'(bus.ram_en_o),        0);
    end
    bus.host_req_i = 1'b0;
    rst_n          = 1'b1;
    idle(1'b0);
    idle(1'b0);

    check("tpu_q_empty",  tpu_q.size(),  0);
    check("host_q_empty", host_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
